// File: rtl/prog_dumper_pkg.sv
// Shared types and constants for the program dumper and its UART transmitter.
package prog_dumper_pkg;

   localparam int   ADR_W      = 21;
   localparam int   FRAME_BITS = 10;
   localparam logic START_LVL  = 1'b0;
   localparam logic STOP_LVL   = 1'b1;
   localparam logic IDLE_LVL   = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_READ = 3'd1,
      ST_SEND = 3'd2,
      ST_CSUM = 3'd3,
      ST_FIN  = 3'd4
   } state_e;

   // Running 8-bit checksum: plain modulo-256 sum of the streamed bytes.
   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter for one byte per load strobe; idles high.
// A load in the same cycle as frame_done starts the next frame with no gap.
module uart_tx_byte
   import prog_dumper_pkg::*;
#(
   parameter int CLK_DIV = 104
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] byte_in,
   output logic       tx,
   output logic       frame_done
);

   localparam int             BW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_DIV - 1);
   localparam logic [3:0]     BIT_LAST  = 4'(FRAME_BITS - 1);

   logic          tx_q, tx_d;
   logic [8:0]    shift_q, shift_d;
   logic [3:0]    bit_q, bit_d;
   logic [BW-1:0] baud_q, baud_d;
   logic          active_q, active_d;
   logic          bit_end_s;

   assign bit_end_s  = active_q && (baud_q == BAUD_LAST);
   assign frame_done = bit_end_s && (bit_q == BIT_LAST);
   assign tx         = tx_q;

   // Next-state: load a new frame, advance to the next bit, or count baud ticks.
   always_comb begin
      tx_d     = tx_q;
      shift_d  = shift_q;
      bit_d    = bit_q;
      baud_d   = baud_q;
      active_d = active_q;
      if (load) begin
         tx_d     = START_LVL;
         shift_d  = {STOP_LVL, byte_in};
         bit_d    = 4'd0;
         baud_d   = {BW{1'b0}};
         active_d = 1'b1;
      end else if (bit_end_s) begin
         baud_d = {BW{1'b0}};
         if (bit_q == BIT_LAST) begin
            active_d = 1'b0;
            tx_d     = IDLE_LVL;
         end else begin
            bit_d   = bit_q + 4'd1;
            tx_d    = shift_q[0];
            shift_d = {IDLE_LVL, shift_q[8:1]};
         end
      end else if (active_q) begin
         baud_d = baud_q + {{(BW-1){1'b0}}, 1'b1};
      end else begin
         baud_d = baud_q;
      end
   end

   // Transmitter state registers; line idles high out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_q     <= IDLE_LVL;
         shift_q  <= 9'h1FF;
         bit_q    <= 4'd0;
         baud_q   <= {BW{1'b0}};
         active_q <= 1'b0;
      end else begin
         tx_q     <= tx_d;
         shift_q  <= shift_d;
         bit_q    <= bit_d;
         baud_q   <= baud_d;
         active_q <= active_d;
      end
   end

endmodule

// File: rtl/prog_dumper.sv
// Program dumper: reads a block of external memory and streams it over UART,
// followed by an 8-bit checksum of the streamed bytes.
module prog_dumper
   import prog_dumper_pkg::*;
#(
   parameter int CLK_DIV   = 104,
   parameter int READ_WAIT = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [ADR_W-1:0] start_adr,
   input  logic [ADR_W-1:0] length,
   output logic [ADR_W-1:0] adr,
   input  logic [7:0]       data,
   output logic             read,
   output logic             tx,
   output logic             busy,
   output logic             done
);

   localparam int            WW        = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(READ_WAIT - 1);

   state_e           state_q, state_d;
   logic [ADR_W-1:0] adr_q, adr_d;
   logic [ADR_W-1:0] cnt_q, cnt_d;
   logic [7:0]       csum_q, csum_d;
   logic [WW-1:0]    wait_q, wait_d;
   logic             read_q, read_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             uart_load_s;
   logic [7:0]       uart_byte_s;
   logic             frame_done_s;

   uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
      .clk        (clk),
      .reset      (reset),
      .load       (uart_load_s),
      .byte_in    (uart_byte_s),
      .tx         (tx),
      .frame_done (frame_done_s)
   );

   // Sequencer: read phase, byte frame, then checksum frame and completion.
   always_comb begin
      state_d     = state_q;
      adr_d       = adr_q;
      cnt_d       = cnt_q;
      csum_d      = csum_q;
      wait_d      = wait_q;
      uart_load_s = 1'b0;
      uart_byte_s = data;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (length != {ADR_W{1'b0}}) begin
                  adr_d   = start_adr;
                  cnt_d   = length;
                  csum_d  = 8'h00;
                  wait_d  = {WW{1'b0}};
                  state_d = ST_READ;
               end else begin
                  state_d = ST_FIN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            if (wait_q == WAIT_LAST) begin
               // Data is sampled on the edge ending the last read cycle.
               uart_load_s = 1'b1;
               uart_byte_s = data;
               csum_d      = csum_add(csum_q, data);
               state_d     = ST_SEND;
            end else begin
               wait_d = wait_q + {{(WW-1){1'b0}}, 1'b1};
            end
         end
         ST_SEND: begin
            if (frame_done_s) begin
               adr_d = adr_q + {{(ADR_W-1){1'b0}}, 1'b1};
               cnt_d = cnt_q - {{(ADR_W-1){1'b0}}, 1'b1};
               if (cnt_q == {{(ADR_W-1){1'b0}}, 1'b1}) begin
                  // Checksum frame follows the last stop bit back to back.
                  uart_load_s = 1'b1;
                  uart_byte_s = csum_q;
                  state_d     = ST_CSUM;
               end else begin
                  wait_d  = {WW{1'b0}};
                  state_d = ST_READ;
               end
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_CSUM: begin
            if (frame_done_s) begin
               state_d = ST_FIN;
            end else begin
               state_d = ST_CSUM;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      read_d = (state_d == ST_READ);
      busy_d = (state_d == ST_READ) || (state_d == ST_SEND) || (state_d == ST_CSUM);
      done_d = (state_d == ST_FIN);
   end

   // State and registered outputs; reset aborts any transfer in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         adr_q   <= {ADR_W{1'b0}};
         cnt_q   <= {ADR_W{1'b0}};
         csum_q  <= 8'h00;
         wait_q  <= {WW{1'b0}};
         read_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         cnt_q   <= cnt_d;
         csum_q  <= csum_d;
         wait_q  <= wait_d;
         read_q  <= read_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign adr  = adr_q;
   assign read = read_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_prog_dumper.sv
// Self-checking bench for prog_dumper: closed-form timing model checked every
// cycle, a UART decoder, and literal expectations for each directed scenario.
module tb_prog_dumper;

   localparam int D  = 4;
   localparam int RW = 2;
   localparam int P  = RW + 10 * D;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [20:0] start_adr = 21'h0;
   logic [20:0] length = 21'h0;
   logic [20:0] adr;
   logic [7:0]  data;
   logic        read, tx, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mem [logic [20:0]];

   prog_dumper #(.CLK_DIV(D), .READ_WAIT(RW)) dut (
      .clk(clk), .reset(reset), .start(start), .start_adr(start_adr),
      .length(length), .adr(adr), .data(data), .read(read), .tx(tx),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] memf(input logic [20:0] a);
      if (mem.exists(a)) return mem[a];
      return 8'h00;
   endfunction

   function automatic logic fbit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return b[k-1];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // memory model: data follows the address, settled well before the sampling edge
   always @(negedge clk) data <= memf(adr);

   // ---------------- behavioural model ----------------
   longint      cyc = 0, m_t0 = 0, m_tend = 0, m_len = 0;
   bit          m_active = 1'b0;
   logic [20:0] m_sa = 21'h0;
   logic [7:0]  m_csum = 8'h00;

   always @(posedge clk or posedge reset) begin : model
      longint     c;
      bit         act;
      logic [7:0] s;
      if (reset) begin
         m_active <= 1'b0;
      end else begin
         c = cyc + 1;
         cyc <= c;
         act = m_active;
         if (act && (c - m_t0 - 1) > m_tend) act = 1'b0;
         if (!act && start === 1'b1) begin
            act = 1'b1;
            m_t0 <= c - 1;
            m_sa <= start_adr;
            m_len <= longint'(length);
            if (length == 21'd0) begin
               m_tend <= 1;
            end else begin
               s = 8'h00;
               for (int i = 0; i < int'(length); i++) s = s + memf(start_adr + 21'(i));
               m_csum <= s;
               m_tend <= longint'(length) * P + 10 * D + 1;
            end
         end
         m_active <= act;
      end
   end

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin : cmp
      longint      t, o;
      int          i;
      logic        e_tx, e_rd, e_busy, e_done;
      logic [20:0] e_adr;
      if (!reset) begin
         e_tx = 1'b1; e_rd = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_adr = 21'h0;
         t = cyc - m_t0;
         if (m_active && t >= 1 && t <= m_tend) begin
            if (t == m_tend) begin
               e_done = 1'b1;
            end else begin
               e_busy = 1'b1;
               if (t <= m_len * P) begin
                  i = int'((t - 1) / P);
                  o = (t - 1) % P;
                  e_adr = m_sa + 21'(i);
                  if (o < RW) e_rd = 1'b1;
                  else e_tx = fbit(memf(e_adr), int'((o - RW) / D));
               end else begin
                  o = t - 1 - m_len * P;
                  e_tx = fbit(m_csum, int'(o / D));
               end
            end
         end
         chk("tx", {31'd0, tx}, {31'd0, e_tx});
         chk("read", {31'd0, read}, {31'd0, e_rd});
         chk("busy", {31'd0, busy}, {31'd0, e_busy});
         chk("done", {31'd0, done}, {31'd0, e_done});
         if (e_rd) chk("adr", {11'd0, adr}, {11'd0, e_adr});
      end
   end

   // ---------------- UART decoder ----------------
   bit         dec_on = 1'b0;
   int         dec_ph = 0;
   logic [7:0] dec_b = 8'h00;
   logic [7:0] rxq[$];

   always @(negedge clk or posedge reset) begin : dec
      int ph;
      if (reset) begin
         dec_on <= 1'b0;
      end else if (!dec_on) begin
         if (tx === 1'b0) begin
            dec_on <= 1'b1;
            dec_ph <= 0;
         end
      end else begin
         ph = dec_ph + 1;
         dec_ph <= ph;
         if ((ph % D) == D / 2 && ph / D >= 1 && ph / D <= 8) dec_b[ph / D - 1] <= tx;
         if (ph == 9 * D + D / 2) begin
            rxq.push_back(dec_b);
            chk("stop_bit", {31'd0, tx}, 32'd1);
            dec_on <= 1'b0;
         end
      end
   end

   // ---------------- activity counters ----------------
   int          rd_cyc = 0, busy_cyc = 0, done_cnt = 0, txlow_cyc = 0;
   logic        prev_rd = 1'b0;
   logic [20:0] raq[$];

   always @(negedge clk) begin
      if (!reset) begin
         rd_cyc    <= rd_cyc + (read ? 1 : 0);
         busy_cyc  <= busy_cyc + (busy ? 1 : 0);
         done_cnt  <= done_cnt + (done ? 1 : 0);
         txlow_cyc <= txlow_cyc + (tx ? 0 : 1);
         if (read && !prev_rd) raq.push_back(adr);
         prev_rd <= read;
      end else begin
         prev_rd <= 1'b0;
      end
   end

   int s_rd, s_busy, s_done, s_txl;

   task automatic snap();
      s_rd = rd_cyc; s_busy = busy_cyc; s_done = done_cnt; s_txl = txlow_cyc;
      rxq.delete();
      raq.delete();
   endtask

   task automatic start_xfer(input logic [20:0] sa, input logic [20:0] len);
      @(negedge clk);
      start = 1'b1; start_adr = sa; length = len;
      @(negedge clk);
      start = 1'b0; start_adr = 21'h0ABCDE; length = 21'd7;
   endtask

   task automatic wait_done(input int budget);
      bit got;
      got = (done === 1'b1);
      for (int k = 0; k < budget && !got; k++) begin
         @(negedge clk);
         if (done === 1'b1) got = 1'b1;
      end
      chk("done_seen", {31'd0, got}, 32'd1);
      repeat (6) @(negedge clk);
   endtask

   task automatic check_rx(input string nm, input int n, input logic [31:0] e);
      chk({nm, "_count"}, rxq.size(), n);
      for (int i = 0; i < n && i < rxq.size(); i++)
         chk({nm, "_byte"}, {24'd0, rxq[i]}, {24'd0, e[8*(n-1-i) +: 8]});
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      mem[21'h000100] = 8'h12; mem[21'h000101] = 8'h34; mem[21'h000102] = 8'hAB;
      mem[21'h000200] = 8'h77; mem[21'h000201] = 8'h66;
      mem[21'h000300] = 8'h55;
      mem[21'h1FFFFF] = 8'h80; mem[21'h000000] = 8'h90;

      // reset state
      @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_read", {31'd0, read}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_adr", {11'd0, adr}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // basic dump
      snap();
      start_xfer(21'h000100, 21'd3);
      wait_done(3 * P + 10 * D + 20);
      check_rx("basic", 4, 32'h1234ABF1);
      chk("basic_done_pulses", done_cnt - s_done, 1);
      chk("basic_busy_cycles", busy_cyc - s_busy, 166);
      chk("basic_read_cycles", rd_cyc - s_rd, 6);
      chk("basic_rd_adr_count", raq.size(), 3);
      if (raq.size() == 3) begin
         chk("basic_rd_adr0", {11'd0, raq[0]}, 32'h100);
         chk("basic_rd_adr1", {11'd0, raq[1]}, 32'h101);
         chk("basic_rd_adr2", {11'd0, raq[2]}, 32'h102);
      end
      chk("basic_busy_after", {31'd0, busy}, 32'd0);

      // bit timing with 0x55
      snap();
      start_xfer(21'h000300, 21'd1);
      wait_done(P + 10 * D + 20);
      check_rx("timing", 2, 32'h00005555);
      chk("timing_busy_cycles", busy_cyc - s_busy, 82);
      chk("timing_tx_low_cycles", txlow_cyc - s_txl, 40);
      chk("timing_read_cycles", rd_cyc - s_rd, 2);

      // address wrap
      snap();
      start_xfer(21'h1FFFFF, 21'd2);
      wait_done(2 * P + 10 * D + 20);
      check_rx("wrap", 3, 32'h00809010);
      chk("wrap_rd_adr_count", raq.size(), 2);
      if (raq.size() == 2) begin
         chk("wrap_rd_adr0", {11'd0, raq[0]}, 32'h1FFFFF);
         chk("wrap_rd_adr1", {11'd0, raq[1]}, 32'h0);
      end

      // length zero
      snap();
      start_xfer(21'h000100, 21'd0);
      chk("len0_done_next_cycle", {31'd0, done}, 32'd1);
      wait_done(5);
      chk("len0_done_pulses", done_cnt - s_done, 1);
      chk("len0_busy_cycles", busy_cyc - s_busy, 0);
      chk("len0_read_cycles", rd_cyc - s_rd, 0);
      chk("len0_tx_low_cycles", txlow_cyc - s_txl, 0);

      // start while busy is ignored
      snap();
      start_xfer(21'h000100, 21'd3);
      repeat (9) @(negedge clk);
      start = 1'b1; start_adr = 21'h000200; length = 21'd5;
      @(negedge clk);
      start = 1'b0;
      wait_done(3 * P + 10 * D + 20);
      check_rx("busy_start", 4, 32'h1234ABF1);
      chk("busy_start_done_pulses", done_cnt - s_done, 1);
      chk("busy_start_busy_cycles", busy_cyc - s_busy, 166);

      // reset during data bit 3 of byte 2
      snap();
      start_xfer(21'h000100, 21'd3);
      repeat (61) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_tx", {31'd0, tx}, 32'd1);
      chk("midrst_read", {31'd0, read}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_adr", {11'd0, adr}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      snap();
      start_xfer(21'h000100, 21'd3);
      wait_done(3 * P + 10 * D + 20);
      check_rx("after_rst", 4, 32'h1234ABF1);
      chk("after_rst_done_pulses", done_cnt - s_done, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_dumper.md
Name: prog_dumper

Overview:
- Counterpart of the program loader: reads a block of the 21-bit external memory bus and streams it out over UART TX to the host, followed by a checksum byte.
- Runs in the clk (UART) domain.
- Bus-muxed in the top level the same way the loader is, selected while the CPU is held in reset.
- Lets the host read back cartridge ROM/RAM contents to verify a load.

Parameters:
- CLK_DIV, 104, clk cycles per UART bit (8N1).
- READ_WAIT, 2, clk cycles read is held asserted per byte; data is sampled on the last of them.

Ports:
- clk  input  1  UART/system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- start_adr  input  21  first byte address, latched at start.
- length  input  21  byte count, latched at start; 0 = no-op.
- adr  output  21  memory address.
- data  input  8  memory read data.
- read  output  1  memory read strobe.
- tx  output  1  UART TX line, idle high.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset values (asynchronous): adr=0, read=0, tx=1, busy=0, done=0, checksum=0, state=IDLE. Reset mid-operation aborts immediately; no partial frame is completed.
- States: IDLE, READ, SEND, CSUM, FIN.
- IDLE:
  - start=1 and length!=0: latch start_adr into adr, load the remaining-byte counter with length, clear checksum. Next cycle: state=READ, read=1, busy=1.
  - start=1 and length=0: next cycle done=1 for one cycle, busy stays 0, no read, no TX.
  - start while busy is ignored.
- READ:
  - read is high for exactly READ_WAIT cycles; adr is stable throughout.
  - data is captured into the shift register on the posedge ending the last read cycle; checksum += data, mod 256.
  - The next cycle: read=0, state=SEND, tx drives the start bit.
- SEND:
  - 8N1 frame: start bit 0, data bits LSB first, stop bit 1.
  - Each bit lasts exactly CLK_DIV cycles, so a frame is 10*CLK_DIV cycles.
  - At the end of the stop bit, decrement the counter and increment adr. adr wraps from 0x1FFFFF to 0x000000.
  - Counter nonzero: enter READ on the next cycle, with read=1 on the new address.
  - Counter zero: enter CSUM.
- CSUM: transmit the checksum byte as one frame, starting immediately after the last data stop bit with no idle gap. The checksum is the 8-bit sum of all data bytes.
- FIN: one cycle, done=1. busy falls in the same cycle. Return to IDLE.
- tx is 1 whenever not inside a frame. Between a stop bit and the next start bit, tx stays 1 for READ_WAIT cycles (the read phase).
- adr holds its last value after completion. It is driven only while busy; top-level muxing is outside this block.

Decomposition:
- Shared package prog_dumper_pkg holds:
  - the state enum (IDLE, READ, SEND, CSUM, FIN);
  - UART frame constants: 10 bits per frame, start bit level 0, stop/idle level 1;
  - address width 21.
- One sub-module, uart_tx_byte:
  - handles the CLK_DIV baud counter, the 10-bit shift and idle-high behaviour;
  - interface: clk, reset, load strobe, byte in, tx out, frame_done pulse;
  - owned by prog_dumper, which sequences reads, the counter, the checksum and the address.

Test Plan:
- Basic dump (bench CLK_DIV=4, READ_WAIT=2): memory 0x00100=0x12, 0x00101=0x34, 0x00102=0xAB; start with start_adr=0x00100, length=3 -> read pulses of 2 cycles at 0x00100, 0x00101, 0x00102. Decoded TX bytes 0x12, 0x34, 0xAB, then checksum 0xF1. One done pulse; busy low afterwards.
- Bit timing: a single byte 0x55 -> start bit low for exactly 4 cycles; bits alternate 1,0,1,0... each for 4 cycles; stop high for 4 cycles; frame 40 cycles; checksum frame 0x55 follows with no gap.
- Address wrap: start_adr=0x1FFFFF, length=2 -> reads at 0x1FFFFF then 0x000000. Checksum equals the sum of both bytes mod 256.
- Length zero: start with length=0 -> done high exactly one cycle later. read, busy and tx are never asserted, tx stays 1.
- Start while busy: a second start pulse during the SEND of byte 1 with different start_adr/length -> ignored; the original 3-byte transfer and checksum are unchanged.
- Reset mid-frame: assert reset during data bit 3 of byte 2 -> tx=1, read=0, busy=0 and adr=0 immediately. A new start after release performs a clean full transfer with the checksum restarted from 0.
